// File: rtl/soft_error_scan_ctrl.sv
// Soft-error detector scanner: synchronizes per-channel error flags, round-robin scans
// them, reports each hit as a handshaked record, then pulses the detector's re-arm reset.
module soft_error_scan_ctrl #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int REARM_CYC = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [N_CH-1:0]           i_err_a,
  input  logic [N_CH-1:0]           i_err_b,
  output logic [N_CH-1:0]           o_det_rst,
  output logic                      o_evt_valid,
  input  logic                      i_evt_ready,
  output logic [$clog2(N_CH)-1:0]   o_evt_ch,
  output logic [1:0]                o_evt_type,
  output logic [CNT_W-1:0]          o_evt_cnt,
  output logic                      o_busy,
  output logic                      o_overflow
);

  localparam int PTR_W = $clog2(N_CH);
  localparam int RC_W  = $clog2(REARM_CYC + 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT, REARM} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0]    sa1_q, sa2_q, sb1_q, sb2_q;
  logic [PTR_W-1:0]   ev_ch_q, ev_ch_d;
  logic [1:0]         ev_type_q, ev_type_d;
  logic [CNT_W-1:0]   ev_cnt_q, ev_cnt_d;
  logic               ovf_q, ovf_d;

  logic               hit_a, hit_b;
  logic [CNT_W-1:0]   cur_cnt;
  logic [PTR_W-1:0]   ptr_next;

  assign hit_a    = sa2_q[ptr_q];
  assign hit_b    = sb2_q[ptr_q];
  assign cur_cnt  = cnt_q[ptr_q];
  assign ptr_next = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rc_d      = rc_q;
    cnt_d     = cnt_q;
    ev_ch_d   = ev_ch_q;
    ev_type_d = ev_type_q;
    ev_cnt_d  = ev_cnt_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: if (i_en) state_d = SCAN;
      SCAN: begin
        if (!i_en) begin
          state_d = IDLE;
        end else if (hit_a || hit_b) begin
          state_d   = REPORT;
          ev_ch_d   = ptr_q;
          ev_type_d = {hit_b, hit_a};
          if (&cur_cnt) begin
            ovf_d    = 1'b1;
            ev_cnt_d = cur_cnt;
          end else begin
            cnt_d[ptr_q] = cur_cnt + 1'b1;
            ev_cnt_d     = cur_cnt + 1'b1;
          end
        end else begin
          ptr_d = ptr_next;
        end
      end
      REPORT: begin
        if (i_evt_ready) begin
          state_d = REARM;
          rc_d    = '0;
        end
      end
      REARM: begin
        // Synchronized errors are not looked at here, so the re-armed channel is ignored.
        if (rc_q == RC_W'(REARM_CYC - 1)) begin
          ptr_d   = ptr_next;
          state_d = i_en ? SCAN : IDLE;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rc_q      <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      sa1_q     <= '0;
      sa2_q     <= '0;
      sb1_q     <= '0;
      sb2_q     <= '0;
      ev_ch_q   <= '0;
      ev_type_q <= '0;
      ev_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rc_q      <= rc_d;
      cnt_q     <= cnt_d;
      sa1_q     <= i_err_a;
      sa2_q     <= sa1_q;
      sb1_q     <= i_err_b;
      sb2_q     <= sb1_q;
      ev_ch_q   <= ev_ch_d;
      ev_type_q <= ev_type_d;
      ev_cnt_q  <= ev_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    o_det_rst = '0;
    if (state_q == REARM) o_det_rst[ptr_q] = 1'b1;
  end

  assign o_evt_valid = (state_q == REPORT);
  assign o_busy      = (state_q != IDLE);
  assign o_evt_ch    = ev_ch_q;
  assign o_evt_type  = ev_type_q;
  assign o_evt_cnt   = ev_cnt_q;
  assign o_overflow  = ovf_q;

endmodule
